// File: rtl/game_controller_if.sv
// Bundle of the controller's game-side signals. Names are seen from the
// controller: i_* flow into it, o_* flow out of it.
interface game_controller_if;
    logic        i_frame_tick;
    logic        i_start;
    logic [31:0] i_random_number;
    logic        i_obj_caught;
    logic        i_obj_landed;
    logic        o_lfsr_enable;
    logic        o_obj_spawn;
    logic [10:0] o_obj_spawn_x;
    logic [3:0]  o_obj_speed;
    logic        o_obj_active;
    logic [15:0] o_score;
    logic [1:0]  o_lives;
    logic        o_game_over;

    // Controller side
    modport slave (
        input  i_frame_tick, i_start, i_random_number, i_obj_caught, i_obj_landed,
        output o_lfsr_enable, o_obj_spawn, o_obj_spawn_x, o_obj_speed,
        output o_obj_active, o_score, o_lives, o_game_over
    );

    // Game top level / stimulus side
    modport master (
        output i_frame_tick, i_start, i_random_number, i_obj_caught, i_obj_landed,
        input  o_lfsr_enable, o_obj_spawn, o_obj_spawn_x, o_obj_speed,
        input  o_obj_active, o_score, o_lives, o_game_over
    );
endinterface

// File: rtl/game_controller.sv
// Game-level sequencer for the falling-object game: schedules spawns on
// frame boundaries, picks a bounded spawn X from the LFSR, and tracks score,
// lives and fall speed. Every output is a register.
module game_controller #(
    parameter int H_ACTIVE         = 640,
    parameter int OBJ_WIDTH        = 32,
    parameter int LIVES            = 3,
    parameter int START_SPEED      = 1,
    parameter int MAX_SPEED        = 8,
    parameter int LEVEL_UP_SCORE   = 10,
    parameter int SPAWN_GAP_FRAMES = 30
) (
    input  logic              i_clk,
    input  logic              i_rst,
    game_controller_if.slave  bus
);

    localparam int LIMIT = H_ACTIVE - OBJ_WIDTH;

    localparam logic [10:0] W_LIMIT     = 11'(LIMIT);
    localparam logic [1:0]  W_LIVES     = 2'(LIVES);
    localparam logic [3:0]  W_START_SPD = 4'(START_SPEED);
    localparam logic [3:0]  W_MAX_SPD   = 4'(MAX_SPEED);
    localparam logic [7:0]  W_LEVEL_UP  = 8'(LEVEL_UP_SCORE);
    localparam logic [7:0]  W_GAP       = 8'(SPAWN_GAP_FRAMES);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT      = 2'd1;
    localparam logic [1:0] S_FALLING   = 2'd2;
    localparam logic [1:0] S_GAME_OVER = 2'd3;

    logic [1:0]  r_state;
    logic [15:0] r_score;
    logic [1:0]  r_lives;
    logic [3:0]  r_speed;
    logic [7:0]  r_gap;
    logic [7:0]  r_level;
    logic        r_spawn;
    logic [10:0] r_spawn_x;
    logic        r_active;
    logic        r_game_over;
    logic        r_lfsr_en;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_score_nxt;
    logic [1:0]  w_lives_nxt;
    logic [3:0]  w_speed_nxt;
    logic [7:0]  w_gap_nxt;
    logic [7:0]  w_level_nxt;
    logic        w_spawn_nxt;
    logic [10:0] w_spawn_x_nxt;

    logic [10:0] w_rand;
    logic [10:0] w_spawn_x_calc;
    logic [7:0]  w_level_inc;
    logic        w_unused_rand;

    // Fold the 10-bit random word into 0..LIMIT (LIMIT >= 511 keeps one fold enough)
    assign w_rand         = {1'b0, bus.i_random_number[9:0]};
    assign w_spawn_x_calc = (w_rand > W_LIMIT) ? (w_rand - W_LIMIT - 11'd1) : w_rand;
    assign w_level_inc    = r_level + 8'd1;
    assign w_unused_rand  = ^bus.i_random_number[31:10];

    // Next-state and next-value decode for the game flow
    always_comb begin
        // NOTE: every target gets a hold/default value first so no path leaves it unassigned and infers a latch.
        w_state_nxt   = r_state;
        w_score_nxt   = r_score;
        w_lives_nxt   = r_lives;
        w_speed_nxt   = r_speed;
        w_gap_nxt     = r_gap;
        w_level_nxt   = r_level;
        w_spawn_nxt   = 1'b0;
        w_spawn_x_nxt = r_spawn_x;

        case (r_state)
            S_IDLE, S_GAME_OVER: begin
                // A frame_tick alongside start is deliberately not counted
                if (bus.i_start) begin
                    w_score_nxt = '0;
                    w_lives_nxt = W_LIVES;
                    w_speed_nxt = W_START_SPD;
                    w_level_nxt = '0;
                    w_gap_nxt   = W_GAP;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.i_frame_tick) begin
                    if (r_gap != 8'd0) begin
                        w_gap_nxt = r_gap - 8'd1;
                    end else begin
                        w_spawn_nxt   = 1'b1;
                        w_spawn_x_nxt = w_spawn_x_calc;
                        w_state_nxt   = S_FALLING;
                    end
                end
            end
            S_FALLING: begin
                // A catch outranks a landing reported in the same cycle
                if (bus.i_obj_caught) begin
                    if (r_score != 16'hFFFF) begin
                        w_score_nxt = r_score + 16'd1;
                    end
                    if (w_level_inc == W_LEVEL_UP) begin
                        w_level_nxt = '0;
                        if (r_speed < W_MAX_SPD) begin
                            w_speed_nxt = r_speed + 4'd1;
                        end
                    end else begin
                        w_level_nxt = w_level_inc;
                    end
                    w_gap_nxt   = W_GAP;
                    w_state_nxt = S_WAIT;
                end else if (bus.i_obj_landed) begin
                    if (r_lives <= 2'd1) begin
                        w_lives_nxt = 2'd0;
                        w_state_nxt = S_GAME_OVER;
                    end else begin
                        w_lives_nxt = r_lives - 2'd1;
                        w_gap_nxt   = W_GAP;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and registered outputs; flags are decoded from the next state so they track r_state
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_score     <= '0;
            r_lives     <= W_LIVES;
            r_speed     <= W_START_SPD;
            r_gap       <= '0;
            r_level     <= '0;
            r_spawn     <= 1'b0;
            r_spawn_x   <= '0;
            r_active    <= 1'b0;
            r_game_over <= 1'b0;
            r_lfsr_en   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_score     <= w_score_nxt;
            r_lives     <= w_lives_nxt;
            r_speed     <= w_speed_nxt;
            r_gap       <= w_gap_nxt;
            r_level     <= w_level_nxt;
            r_spawn     <= w_spawn_nxt;
            r_spawn_x   <= w_spawn_x_nxt;
            r_active    <= (w_state_nxt == S_FALLING);
            r_game_over <= (w_state_nxt == S_GAME_OVER);
            r_lfsr_en   <= (w_state_nxt != S_GAME_OVER);
        end
    end

    assign bus.o_lfsr_enable = r_lfsr_en;
    assign bus.o_obj_spawn   = r_spawn;
    assign bus.o_obj_spawn_x = r_spawn_x;
    assign bus.o_obj_speed   = r_speed;
    assign bus.o_obj_active  = r_active;
    assign bus.o_score       = r_score;
    assign bus.o_lives       = r_lives;
    assign bus.o_game_over   = r_game_over;

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Game-level sequencer for the falling-object datapath. Runs the IDLE / WAIT_SPAWN / FALLING / GAME_OVER flow.
- Schedules object spawns on frame boundaries and derives a bounded spawn X from the LFSR word.
- Tracks score, lives and fall speed. Drives the object block and gates the LFSR.
- Sits between lfsr, object and vga_synchronization in the game top level, all on the 25 MHz pixel clock.

Parameters:
- H_ACTIVE, 640, visible line width in pixels
- OBJ_WIDTH, 32, object width in pixels; LIMIT = H_ACTIVE-OBJ_WIDTH must satisfy 511 <= LIMIT <= 1022
- LIVES, 3, lives at game start (1..3)
- START_SPEED, 1, initial fall speed in pixels/frame (1..15)
- MAX_SPEED, 8, speed saturation value (START_SPEED..15)
- LEVEL_UP_SCORE, 10, catches per speed increment (1..255)
- SPAWN_GAP_FRAMES, 30, frames between an object resolving and the next spawn (0..255)

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- start  in  1  level or pulse; sampled every cycle
- random_number  in  32  LFSR output; only bits [9:0] are used
- obj_caught  in  1  one-cycle pulse: player caught the current object
- obj_landed  in  1  one-cycle pulse: object reached the bottom uncaught
- lfsr_enable  out  1  LFSR advance enable
- obj_spawn  out  1  one-cycle pulse: load a new object at obj_spawn_x, Y=0
- obj_spawn_x  out  11  spawn X, 0..LIMIT
- obj_speed  out  4  fall speed in pixels/frame
- obj_active  out  1  high while an object is falling
- score  out  16  catch count, saturating at 16'hFFFF
- lives  out  2  remaining lives
- game_over  out  1  high in GAME_OVER

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; score=0; lives=LIVES; obj_speed=START_SPEED.
  - obj_spawn=0; obj_spawn_x=0; obj_active=0; game_over=0; lfsr_enable=1.
  - Gap counter=0; level counter=0.
  - Reset mid-game aborts any pending spawn; no obj_spawn pulse follows.
- All outputs are registered. obj_active=(state==FALLING); game_over=(state==GAME_OVER); lfsr_enable=(state!=GAME_OVER).
- IDLE:
  - start=1 -> score=0, lives=LIVES, obj_speed=START_SPEED, level counter=0, gap counter=SPAWN_GAP_FRAMES, go WAIT_SPAWN.
  - A frame_tick in the same cycle as start is not counted.
- WAIT_SPAWN:
  - On frame_tick with gap counter>0: decrement the counter.
  - On frame_tick with gap counter==0: obj_spawn=1 for exactly one cycle (the cycle after the tick edge), obj_spawn_x loads, go FALLING.
  - SPAWN_GAP_FRAMES=0 spawns on the first frame_tick.
  - obj_caught and obj_landed are ignored.
- Spawn X:
  - r=random_number[9:0], sampled at the spawn decision edge.
  - obj_spawn_x = (r > LIMIT) ? r-LIMIT-1 : r, zero-extended to 11 bits.
  - obj_spawn_x holds until the next spawn.
- FALLING:
  - obj_caught=1:
    - score+1 (saturate at 16'hFFFF); level counter+1.
    - If level counter reaches LEVEL_UP_SCORE: counter=0 and obj_speed+1, saturating at MAX_SPEED.
    - gap counter=SPAWN_GAP_FRAMES; go WAIT_SPAWN.
  - obj_landed=1 (and obj_caught=0):
    - lives-1.
    - If lives was 1 -> lives=0, go GAME_OVER. Otherwise gap counter=SPAWN_GAP_FRAMES, go WAIT_SPAWN.
  - obj_caught and obj_landed in the same cycle: the catch wins; lives are unchanged.
  - frame_tick is ignored.
- GAME_OVER:
  - score, lives and obj_speed are frozen; LFSR is frozen.
  - start=1 -> same initialisation as from IDLE, go WAIT_SPAWN.
- start is ignored in WAIT_SPAWN and FALLING; there is no pause.
- Event latency: caught/landed input at edge N -> score/lives/state updated at edge N (visible after N).

Test Plan:
- Reset then start=1 for 1 cycle -> WAIT_SPAWN, lives=3, score=0, obj_speed=1. 30 frame_ticks produce no spawn; the 31st gives a single obj_spawn pulse and obj_active=1.
- random_number[9:0] = 0, 608, 609, 1023 at spawn -> obj_spawn_x = 0, 608, 0, 414.
- 10 spawn/obj_caught cycles -> score=10, obj_speed=2. Continue to 80 catches -> obj_speed saturates at 8. At 90 catches obj_speed stays 8.
- 3 obj_landed events -> lives 2,1,0, GAME_OVER, game_over=1, lfsr_enable=0. A further obj_caught leaves score unchanged. start -> lives=3, score=0, WAIT_SPAWN.
- obj_caught and obj_landed in the same cycle while FALLING with lives=1 -> score+1, lives=1, WAIT_SPAWN.
- rst=1 while in WAIT_SPAWN with gap counter=5 -> IDLE, all outputs at reset values. Subsequent frame_ticks produce no obj_spawn.
